pe_mac_pipe: RTL and testbench

//  Second-generation systolic processing element: weight-stationary, double-buffered weights, 2-stage MAC.

---
 rtl/pe_mac_pipe_pkg.sv | 18 +
 rtl/pe_mac_pipe_if.sv | 34 +++
 rtl/pe_mac_pipe_sat_add.sv | 33 +++
 rtl/pe_mac_pipe.sv | 132 +++++++++++++
 tb/tb_pe_mac_pipe.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_mac_pipe_pkg.sv
// Shared types for the weight-stationary MAC processing element.
// Holds the per-beat sideband struct and the width sanity check.
package utpu_pe_pkg;

    typedef struct packed {
        logic valid;
        logic signed_mode;
        logic acc_local;
        logic clear;
        logic sat_en;
    } pe_beat_t;

    // The accumulator must hold a full product plus at least one headroom bit.
    function automatic bit widths_ok(input int cdw, input int aw);
        return aw >= (2 * cdw + 1);
    endfunction

endpackage

// File: rtl/pe_mac_pipe_if.sv
// Port bundle of one processing element: west/north inputs, weight loading, east/south outputs.
// The master side drives the PE, and the PE itself attaches through the slave side.
interface pe_mac_pipe_if #(
    parameter int CDW = 4,
    parameter int AW  = 16
);
    logic [CDW-1:0] act_in;
    logic           act_valid_in;
    logic           signed_mode;
    logic           acc_local;
    logic           clear;
    logic           sat_en;
    logic [AW-1:0]  psum_in;
    logic [CDW-1:0] w_in;
    logic           w_load;
    logic           w_swap;
    logic [CDW-1:0] act_out;
    logic           act_valid_out;
    logic [AW-1:0]  psum_out;
    logic           psum_valid_out;
    logic           overflow;

    modport master (
        output act_in, act_valid_in, signed_mode, acc_local, clear, sat_en,
               psum_in, w_in, w_load, w_swap,
        input  act_out, act_valid_out, psum_out, psum_valid_out, overflow
    );

    modport slave (
        input  act_in, act_valid_in, signed_mode, acc_local, clear, sat_en,
               psum_in, w_in, w_load, w_swap,
        output act_out, act_valid_out, psum_out, psum_valid_out, overflow
    );
endinterface

// File: rtl/pe_mac_pipe_sat_add.sv
// Combinational AW-bit adder with signed/unsigned overflow detection and optional clamping.
module pe_sat_add #(
    parameter int AW = 16
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic          signed_mode,
    input  logic          sat_en,
    output logic [AW-1:0] result,
    output logic          ovf
);
    logic [AW:0] ext_a;
    logic [AW:0] ext_b;
    logic [AW:0] sum;

    always_comb begin
        ext_a  = {signed_mode & a[AW-1], a};
        ext_b  = {signed_mode & b[AW-1], b};
        sum    = ext_a + ext_b;
        // Signed overflow shows as disagreement between the guard bit and the AW-bit sign.
        ovf    = signed_mode ? (sum[AW] ^ sum[AW-1]) : sum[AW];
        result = sum[AW-1:0];
        if (ovf && sat_en) begin
            if (!signed_mode) begin
                result = '1;
            end else if (sum[AW]) begin
                result = {1'b1, {(AW-1){1'b0}}};
            end else begin
                result = {1'b0, {(AW-1){1'b1}}};
            end
        end
    end
endmodule

// File: rtl/pe_mac_pipe.sv
// Weight-stationary systolic PE: double-buffered weight, 2-stage MAC, act forwarded east in 1 cycle.
module pe_mac_pipe
    import utpu_pe_pkg::*;
#(
    parameter int COMPUTE_DATA_WIDTH     = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_mac_pipe_if.slave  pe
);
    localparam int CDW = COMPUTE_DATA_WIDTH;
    localparam int AW  = ACCUMULATOR_DATA_WIDTH;

    generate
        if (!widths_ok(CDW, AW)) begin : g_width_err
            $error("pe_mac_pipe: ACCUMULATOR_DATA_WIDTH must be >= 2*COMPUTE_DATA_WIDTH+1");
        end
    endgenerate

    logic [CDW-1:0]   w_shadow_q, w_shadow_d;
    logic [CDW-1:0]   w_active_q, w_active_d;
    logic [CDW-1:0]   act_q, act_d;
    logic             act_valid_q, act_valid_d;
    pe_beat_t         s1_beat_q, s1_beat_d;
    logic [AW-1:0]    s1_prod_q, s1_prod_d;
    logic [AW-1:0]    s1_psum_q, s1_psum_d;
    logic [AW-1:0]    psum_out_q, psum_out_d;
    logic             psum_valid_q, psum_valid_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic [2*CDW-1:0] prod_s;
    logic [2*CDW-1:0] prod_u;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    sum_res;
    logic             sum_ovf;

    // Weights and the east-bound activation register; the multiply sees the pre-swap weight.
    always_comb begin
        w_shadow_d  = pe.w_load ? pe.w_in : w_shadow_q;
        w_active_d  = pe.w_swap ? w_shadow_q : w_active_q;
        act_d       = pe.act_in;
        act_valid_d = pe.act_valid_in;
    end

    always_comb begin
        prod_s = $signed({{CDW{pe.act_in[CDW-1]}}, pe.act_in}) *
                 $signed({{CDW{w_active_q[CDW-1]}}, w_active_q});
        prod_u = {{CDW{1'b0}}, pe.act_in} * {{CDW{1'b0}}, w_active_q};

        s1_beat_d = '0;
        s1_prod_d = s1_prod_q;
        s1_psum_d = s1_psum_q;
        if (pe.act_valid_in || pe.clear) begin
            s1_beat_d.valid       = pe.act_valid_in;
            s1_beat_d.signed_mode = pe.signed_mode;
            s1_beat_d.acc_local   = pe.acc_local;
            s1_beat_d.clear       = pe.clear;
            s1_beat_d.sat_en      = pe.sat_en;
            s1_prod_d = pe.signed_mode ? {{(AW-2*CDW){prod_s[2*CDW-1]}}, prod_s}
                                       : {{(AW-2*CDW){1'b0}}, prod_u};
            s1_psum_d = pe.psum_in;
        end
    end

    always_comb begin
        addend = s1_beat_q.acc_local ? (s1_beat_q.clear ? '0 : acc_q) : s1_psum_q;
    end

    pe_sat_add #(.AW(AW)) u_sat_add (
        .a           (addend),
        .b           (s1_prod_q),
        .signed_mode (s1_beat_q.signed_mode),
        .sat_en      (s1_beat_q.sat_en),
        .result      (sum_res),
        .ovf         (sum_ovf)
    );

    // A clear on a valid beat wipes the old flag first, so its own overflow still registers.
    always_comb begin
        psum_out_d   = psum_out_q;
        psum_valid_d = 1'b0;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        if (s1_beat_q.valid) begin
            psum_out_d   = sum_res;
            psum_valid_d = 1'b1;
            if (s1_beat_q.acc_local) begin
                acc_d = sum_res;
            end
            ovf_d = (s1_beat_q.clear ? 1'b0 : ovf_q) | sum_ovf;
        end else if (s1_beat_q.clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_shadow_q   <= '0;
            w_active_q   <= '0;
            act_q        <= '0;
            act_valid_q  <= 1'b0;
            s1_beat_q    <= '0;
            s1_prod_q    <= '0;
            s1_psum_q    <= '0;
            psum_out_q   <= '0;
            psum_valid_q <= 1'b0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            w_shadow_q   <= w_shadow_d;
            w_active_q   <= w_active_d;
            act_q        <= act_d;
            act_valid_q  <= act_valid_d;
            s1_beat_q    <= s1_beat_d;
            s1_prod_q    <= s1_prod_d;
            s1_psum_q    <= s1_psum_d;
            psum_out_q   <= psum_out_d;
            psum_valid_q <= psum_valid_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
        end
    end

    assign pe.act_out        = act_q;
    assign pe.act_valid_out  = act_valid_q;
    assign pe.psum_out       = psum_out_q;
    assign pe.psum_valid_out = psum_valid_q;
    assign pe.overflow       = ovf_q;
endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed-vector bench for pe_mac_pipe (CDW=4, AW=16) with hand-computed expectations.
module tb_pe_mac_pipe;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    pe_mac_pipe_if #(.CDW(4), .AW(16)) bus ();

    pe_mac_pipe #(
        .COMPUTE_DATA_WIDTH     (4),
        .ACCUMULATOR_DATA_WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pe    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.act_in       = '0;
        bus.act_valid_in = 1'b0;
        bus.signed_mode  = 1'b0;
        bus.acc_local    = 1'b0;
        bus.clear        = 1'b0;
        bus.sat_en       = 1'b0;
        bus.psum_in      = '0;
        bus.w_load       = 1'b0;
        bus.w_swap       = 1'b0;
    endtask

    task automatic beat(input logic [3:0] a, input logic [15:0] p,
                        input logic sg, input logic al, input logic cl, input logic sat);
        bus.act_in       = a;
        bus.act_valid_in = 1'b1;
        bus.psum_in      = p;
        bus.signed_mode  = sg;
        bus.acc_local    = al;
        bus.clear        = cl;
        bus.sat_en       = sat;
    endtask

    task automatic load_w(input logic [3:0] w);
        bus.w_in   = w;
        bus.w_load = 1'b1;
        step();
        bus.w_load = 1'b0;
        bus.w_swap = 1'b1;
        step();
        bus.w_swap = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.w_in     = '0;
        idle();

        // Reset state
        repeat (3) step();
        chk("rst_psum_out", 32'(bus.psum_out), 32'h0);
        chk("rst_psum_valid", 32'(bus.psum_valid_out), 32'h0);
        chk("rst_act_valid_out", 32'(bus.act_valid_out), 32'h0);
        chk("rst_overflow", 32'(bus.overflow), 32'h0);
        rst_n = 1'b1;
        step();

        // Basic unsigned MAC: 5*3 + 10
        load_w(4'd3);
        beat(4'd5, 16'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        chk("basic_act_out", 32'(bus.act_out), 32'd5);
        chk("basic_act_valid_out", 32'(bus.act_valid_out), 32'h1);
        chk("basic_psum_valid_1cyc", 32'(bus.psum_valid_out), 32'h0);
        step();
        chk("basic_psum_out", 32'(bus.psum_out), 32'd25);
        chk("basic_psum_valid_2cyc", 32'(bus.psum_valid_out), 32'h1);
        step();
        chk("basic_psum_valid_drop", 32'(bus.psum_valid_out), 32'h0);
        chk("basic_psum_hold", 32'(bus.psum_out), 32'd25);

        // Double buffering: active=0, shadow=2; load 7 and swap on the same edge
        load_w(4'd0);
        bus.w_in   = 4'd2;
        bus.w_load = 1'b1;
        step();
        bus.w_load = 1'b0;
        beat(4'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.w_in   = 4'd7;
        bus.w_load = 1'b1;
        bus.w_swap = 1'b1;
        step();
        bus.w_load = 1'b0;
        bus.w_swap = 1'b0;
        step();
        chk("dbuf_beat_w0", 32'(bus.psum_out), 32'd0);
        bus.w_swap = 1'b1;
        step();
        bus.w_swap = 1'b0;
        chk("dbuf_beat_w2a", 32'(bus.psum_out), 32'd2);
        step();
        idle();
        chk("dbuf_beat_w2b", 32'(bus.psum_out), 32'd2);
        step();
        chk("dbuf_beat_w7", 32'(bus.psum_out), 32'd7);

        // Signed products: w=-8
        load_w(4'h8);
        beat(4'h7, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        beat(4'h8, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        chk("signed_neg56", 32'(bus.psum_out), 32'h0000FFC8);
        step();
        chk("signed_pos64", 32'(bus.psum_out), 32'h00000040);
        chk("signed_no_ovf", 32'(bus.overflow), 32'h0);

        // Signed overflow: 32760 + 49, saturating then wrapping
        load_w(4'd7);
        beat(4'd7, 16'd32760, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        beat(4'd7, 16'd32760, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        chk("sat_clamp", 32'(bus.psum_out), 32'h00007FFF);
        chk("sat_overflow", 32'(bus.overflow), 32'h1);
        step();
        chk("wrap_value", 32'(bus.psum_out), 32'h00008029);
        chk("wrap_overflow_sticky", 32'(bus.overflow), 32'h1);

        // Clear-only beat resets the overflow flag without producing a result
        bus.clear = 1'b1;
        step();
        idle();
        step();
        chk("clronly_overflow", 32'(bus.overflow), 32'h0);
        chk("clronly_no_valid", 32'(bus.psum_valid_out), 32'h0);
        chk("clronly_psum_hold", 32'(bus.psum_out), 32'h00008029);

        // Local accumulation: 4 beats of 2*3, first one clears
        load_w(4'd3);
        beat(4'd2, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        beat(4'd2, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("acc_beat1", 32'(bus.psum_out), 32'd6);
        step();
        chk("acc_beat2", 32'(bus.psum_out), 32'd12);
        step();
        idle();
        chk("acc_beat3", 32'(bus.psum_out), 32'd18);
        step();
        chk("acc_beat4", 32'(bus.psum_out), 32'd24);

        // Clear-only beat zeroes the accumulator; then psum mode leaves it alone
        bus.clear = 1'b1;
        step();
        idle();
        step();
        beat(4'd2, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        beat(4'd2, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        beat(4'd2, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("acc_after_clear", 32'(bus.psum_out), 32'd6);
        step();
        idle();
        chk("psum_mode_mix", 32'(bus.psum_out), 32'd106);
        step();
        chk("acc_untouched_by_psum", 32'(bus.psum_out), 32'd12);

        // Asynchronous reset mid-stream, between clock edges
        load_w(4'd5);
        beat(4'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_act_out", 32'(bus.act_out), 32'h0);
        chk("arst_act_valid_out", 32'(bus.act_valid_out), 32'h0);
        chk("arst_psum_out", 32'(bus.psum_out), 32'h0);
        chk("arst_psum_valid", 32'(bus.psum_valid_out), 32'h0);
        rst_n = 1'b1;
        step();
        chk("arst_dropped_beat_a", 32'(bus.psum_valid_out), 32'h0);
        step();
        chk("arst_dropped_beat_b", 32'(bus.psum_valid_out), 32'h0);
        beat(4'd3, 16'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        chk("arst_weight_zeroed", 32'(bus.psum_out), 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
